// File: rtl/multicycle_controller_pkg.sv
// Shared opcode, state and decode definitions for the accumulator CPU
// controller and its datapath decoder.
package multicycle_controller_pkg;

    localparam int unsigned OP_BITS = 3;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_BITS-1:0] OP_HLT = 3'd0;
    localparam logic [OP_BITS-1:0] OP_SKZ = 3'd1;
    localparam logic [OP_BITS-1:0] OP_ADD = 3'd2;
    localparam logic [OP_BITS-1:0] OP_AND = 3'd3;
    localparam logic [OP_BITS-1:0] OP_XOR = 3'd4;
    localparam logic [OP_BITS-1:0] OP_LDA = 3'd5;
    localparam logic [OP_BITS-1:0] OP_STO = 3'd6;
    localparam logic [OP_BITS-1:0] OP_JMP = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        ST_INST_ADDR  = 4'd0,
        ST_INST_FETCH = 4'd1,
        ST_INST_LOAD  = 4'd2,
        ST_IDLE       = 4'd3,
        ST_OP_ADDR    = 4'd4,
        ST_OP_FETCH   = 4'd5,
        ST_ALU_OP     = 4'd6,
        ST_STORE      = 4'd7,
        ST_HALTED     = 4'd8
    } state_e;

    // Opcodes that read an operand from memory into the accumulator.
    function automatic logic is_aluop(input logic [OP_BITS-1:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the accumulator CPU: memory wait states,
// latched halt with resume, illegal-opcode trap and optional fast path.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int unsigned OPCODE_W  = 3,
    parameter bit          FAST_PATH = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                resume,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                wr,
    output logic                data_e,
    output logic                illegal,
    output logic                instr_done,
    output logic [STATE_W-1:0]  state_o
);

    state_e             r_state;
    state_e             w_next_state;
    logic               r_illegal;
    logic               w_illegal_op;
    logic [OP_BITS-1:0] w_op;
    logic               w_aluop;
    logic               w_hlt;
    logic               w_skz;
    logic               w_jmp;
    logic               w_sto;

    // Any set bit above the 3-bit opcode field marks the instruction illegal.
    if (OPCODE_W > OP_BITS) begin : g_wide_op
        assign w_illegal_op = |opcode[OPCODE_W-1:OP_BITS];
    end else begin : g_narrow_op
        assign w_illegal_op = 1'b0;
    end

    // Illegal opcodes execute as HLT.
    assign w_op    = w_illegal_op ? OP_HLT : opcode[OP_BITS-1:0];
    assign w_aluop = is_aluop(w_op);
    assign w_hlt   = (w_op == OP_HLT);
    assign w_skz   = (w_op == OP_SKZ);
    assign w_jmp   = (w_op == OP_JMP);
    assign w_sto   = (w_op == OP_STO);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_INST_ADDR;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_OP_ADDR) && w_hlt) begin
                r_illegal <= w_illegal_op;
            end else if ((r_state == ST_HALTED) && resume) begin
                r_illegal <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        sel          = 1'b0;
        rd           = 1'b0;
        ld_ir        = 1'b0;
        halt         = 1'b0;
        inc_pc       = 1'b0;
        ld_ac        = 1'b0;
        ld_pc        = 1'b0;
        wr           = 1'b0;
        data_e       = 1'b0;
        illegal      = 1'b0;
        instr_done   = 1'b0;
        state_o      = r_state;

        case (r_state)
            ST_INST_ADDR: begin
                sel          = 1'b1;
                w_next_state = ST_INST_FETCH;
            end
            ST_INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
                if (mem_ready) begin
                    w_next_state = ST_INST_LOAD;
                end
            end
            ST_INST_LOAD: begin
                sel          = 1'b1;
                rd           = 1'b1;
                ld_ir        = 1'b1;
                w_next_state = ST_IDLE;
            end
            ST_IDLE: begin
                sel          = 1'b1;
                illegal      = w_illegal_op;
                w_next_state = ST_OP_ADDR;
            end
            ST_OP_ADDR: begin
                inc_pc     = 1'b1;
                illegal    = w_illegal_op;
                instr_done = w_hlt;
                if (w_hlt) begin
                    w_next_state = ST_HALTED;
                end else if (FAST_PATH && (w_skz || w_jmp)) begin
                    w_next_state = ST_ALU_OP;
                end else begin
                    w_next_state = ST_OP_FETCH;
                end
            end
            ST_OP_FETCH: begin
                rd = w_aluop;
                if (!w_aluop || mem_ready) begin
                    w_next_state = ST_ALU_OP;
                end
            end
            ST_ALU_OP: begin
                rd     = w_aluop;
                ld_ac  = w_aluop;
                ld_pc  = w_jmp;
                inc_pc = w_skz && zero;
                if (FAST_PATH && !w_sto) begin
                    instr_done   = 1'b1;
                    w_next_state = ST_INST_ADDR;
                end else begin
                    w_next_state = ST_STORE;
                end
            end
            ST_STORE: begin
                wr         = w_sto;
                data_e     = w_sto;
                instr_done = 1'b1;
                if (!w_sto || mem_ready) begin
                    w_next_state = ST_INST_ADDR;
                end
            end
            ST_HALTED: begin
                halt    = 1'b1;
                illegal = r_illegal;
                if (resume) begin
                    w_next_state = ST_INST_ADDR;
                end
            end
            default: begin
                w_next_state = ST_INST_ADDR;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: dut 0 is the plain sequencer, dut 1 the fast-path variant,
// both with a 4-bit opcode so the illegal-opcode trap can be exercised.
module tb_multicycle_controller;

    typedef struct packed {
        logic        d;
        logic [15:0] n;
        logic [3:0]  s;
        logic [10:0] o;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opc [2];
    logic        zr  [2];
    logic        mr  [2];
    logic        rs  [2];
    logic [10:0] obs [2];
    logic [3:0]  st  [2];

    exp_t        sbq [$];
    int          errors = 0;
    int          checks = 0;
    int          seq    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, illegal, instr_done;
        logic [3:0] state_o;

        multicycle_controller #(
            .OPCODE_W  (4),
            .FAST_PATH (1'(g))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .opcode     (opc[g]),
            .zero       (zr[g]),
            .mem_ready  (mr[g]),
            .resume     (rs[g]),
            .sel        (sel),
            .rd         (rd),
            .ld_ir      (ld_ir),
            .halt       (halt),
            .inc_pc     (inc_pc),
            .ld_ac      (ld_ac),
            .ld_pc      (ld_pc),
            .wr         (wr),
            .data_e     (data_e),
            .illegal    (illegal),
            .instr_done (instr_done),
            .state_o    (state_o)
        );

        assign obs[g] = {sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, illegal, instr_done};
        assign st[g]  = state_o;
    end

    // Strobe table per state; packed as {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e,illegal,instr_done}.
    function automatic logic [10:0] exp_out(int s, logic [2:0] eff, logic z, logic ill, logic done);
        logic alu;
        logic [10:0] v;
        alu = (eff >= 3'd2) && (eff <= 3'd5);
        v   = '0;
        case (s)
            0: v[10] = 1'b1;
            1: v[10:9] = 2'b11;
            2: v[10:8] = 3'b111;
            3: begin v[10] = 1'b1; v[1] = ill; end
            4: begin v[6] = 1'b1; v[1] = ill; end
            5: v[9] = alu;
            6: begin v[9] = alu; v[5] = alu; v[4] = (eff == 3'd7); v[6] = (eff == 3'd1) && z; end
            7: begin v[3] = (eff == 3'd6); v[2] = (eff == 3'd6); end
            8: begin v[7] = 1'b1; v[1] = ill; end
            default: v = '0;
        endcase
        v[0] = done;
        return v;
    endfunction

    task automatic push(int d, int s, logic [10:0] o);
        sbq.push_back('{d: 1'(d), n: 16'(seq), s: 4'(s), o: o});
        seq++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(int d, int s, logic [2:0] eff, logic z, logic ill, logic done, logic m, logic r);
        mr[d] = m;
        rs[d] = r;
        push(d, s, exp_out(s, eff, z, ill, done));
        step();
    endtask

    // One instruction from INST_ADDR; w1/w5/w7 are wait cycles requested in the
    // wait-capable states. With abort set, stops at the final STORE cycle unpushed.
    task automatic run_instr(int d, logic [3:0] op, logic z, int w1, int w5, int w7, bit abort);
        logic       legal;
        logic [2:0] eff;
        logic       alu;
        int         path [$];
        legal = (op[3] == 1'b0);
        eff   = legal ? op[2:0] : 3'd0;
        alu   = (eff >= 3'd2) && (eff <= 3'd5);
        if (eff == 3'd0)                     path = {0, 1, 2, 3, 4};
        else if (d == 0 || eff == 3'd6)      path = {0, 1, 2, 3, 4, 5, 6, 7};
        else if (eff == 3'd1 || eff == 3'd7) path = {0, 1, 2, 3, 4, 6};
        else                                 path = {0, 1, 2, 3, 4, 5, 6};
        opc[d] = op;
        zr[d]  = z;
        foreach (path[i]) begin
            int   s;
            int   nw;
            logic capable;
            logic last;
            s       = path[i];
            nw      = 0;
            capable = 1'b0;
            if (s == 1)                  begin capable = 1'b1; nw = w1; end
            if (s == 5 && alu)           begin capable = 1'b1; nw = w5; end
            if (s == 7 && eff == 3'd6)   begin capable = 1'b1; nw = w7; end
            last = (i == path.size() - 1);
            for (int k = 0; k <= nw; k++) begin
                logic m;
                if (abort && last && k == nw) return;
                m = capable ? (k == nw) : 1'($urandom_range(0, 1));
                cyc(d, s, eff, z, !legal, last, m, 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic run_halt(int d, logic ill, int n, bit do_resume);
        for (int k = 0; k < n; k++) begin
            opc[d] = 4'($urandom);
            cyc(d, 8, 3'd0, zr[d], ill, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        if (do_resume) cyc(d, 8, 3'd0, zr[d], ill, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    endtask

    // Reset lands mid-cycle; the state is checked before any clock edge.
    task automatic reset_now(int d, logic r);
        rs[d] = r;
        mr[d] = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (st[d] !== 4'd0 || obs[d] !== exp_out(0, 3'd0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL dut%0d reset: state=%0d outs=%b, required state=0 outs=%b",
                     d, st[d], obs[d], exp_out(0, 3'd0, 1'b0, 1'b0, 1'b0));
        end
        push(d, 0, exp_out(0, 3'd0, 1'b0, 1'b0, 1'b0));
        step();
        rst   = 1'b1;
        rs[d] = 1'b0;
    endtask

    task automatic run_random(int d, int n);
        for (int i = 0; i < n; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? {1'b1, 3'($urandom)} : {1'b0, 3'($urandom)};
            run_instr(d, op, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
            if (op[3] || op[2:0] == 3'd0) run_halt(d, op[3], $urandom_range(0, 3), 1'b1);
        end
    endtask

    // Monitor: one comparison per scoreboard entry, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                checks++;
                if (st[e.d] !== e.s || obs[e.d] !== e.o) begin
                    errors++;
                    $display("FAIL dut%0d step%0d: state=%0d outs=%b, required state=%0d outs=%b",
                             e.d, e.n, st[e.d], obs[e.d], e.s, e.o);
                end
            end
        end
    end

    // Watchdog: the run must finish within the time bound.
    initial begin
        #5000000;
        errors++;
        $display("FAIL timeout: wait expired with %0d records pending", sbq.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            opc[d] = 4'd0;
            zr[d]  = 1'b0;
            mr[d]  = 1'b1;
            rs[d]  = 1'b0;
        end
        step();

        reset_now(0, 1'b0);
        run_instr(0, 4'd2, 1'b0, 0, 0, 0, 1'b0);
        run_instr(0, 4'd2, 1'b1, 0, 0, 0, 1'b0);
        run_instr(0, 4'd5, 1'b0, 3, 2, 0, 1'b0);
        run_instr(0, 4'd1, 1'b1, 0, 0, 0, 1'b0);
        run_instr(0, 4'd1, 1'b0, 0, 0, 0, 1'b0);
        run_instr(0, 4'd7, 1'b1, 0, 0, 0, 1'b0);
        run_instr(0, 4'd0, 1'b0, 0, 0, 0, 1'b0);
        run_halt(0, 1'b0, 4, 1'b1);
        run_instr(0, 4'b1010, 1'b0, 1, 0, 0, 1'b0);
        run_halt(0, 1'b1, 2, 1'b1);
        run_instr(0, 4'd6, 1'b0, 0, 0, 2, 1'b1);
        reset_now(0, 1'b0);
        run_random(0, 40);

        reset_now(1, 1'b0);
        run_instr(1, 4'd1, 1'b1, 0, 0, 0, 1'b0);
        run_instr(1, 4'd7, 1'b0, 0, 0, 0, 1'b0);
        run_instr(1, 4'd2, 1'b0, 0, 0, 0, 1'b0);
        run_instr(1, 4'd6, 1'b1, 0, 0, 0, 1'b0);
        run_instr(1, 4'd0, 1'b0, 0, 0, 0, 1'b0);
        run_halt(1, 1'b0, 1, 1'b1);
        run_instr(1, 4'b1100, 1'b0, 0, 0, 0, 1'b0);
        run_halt(1, 1'b1, 3, 1'b0);
        reset_now(1, 1'b1);
        run_instr(1, 4'd0, 1'b1, 0, 0, 0, 1'b0);
        run_halt(1, 1'b0, 1, 1'b1);
        run_random(1, 40);

        step();
        step();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d records never compared", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle sequencer for the accumulator RISC CPU, the next generation of the fixed 8-state controller. It drives the datapath strobes (address mux, memory read/write, IR/AC/PC loads) from the decoded opcode and ALU zero flag. Over the fixed controller it adds:
- a memory wait-state handshake;
- a latched HALTED state with resume;
- illegal-opcode trapping;
- an optional fast path that skips unused cycles.

## Interface
Parameters:
- OPCODE_W, default 3: opcode input width, ≥3. Bits above [2:0] must be zero, otherwise the opcode is illegal.
- FAST_PATH, default 0: when 1, skip OP_FETCH and STORE for opcodes that do not use them.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- opcode  in  OPCODE_W  opcode from the IR; stable from IDLE onward.
- zero  in  1  accumulator-zero flag from the ALU.
- mem_ready  in  1  memory handshake; when 0 in a wait-capable state, the FSM holds.
- resume  in  1  leaves HALTED when sampled high.
- sel  out  1  address mux select; 1 = PC, 0 = IR operand address.
- rd  out  1  memory read enable.
- ld_ir  out  1  load instruction register.
- halt  out  1  CPU halted.
- inc_pc  out  1  increment PC.
- ld_ac  out  1  load accumulator.
- ld_pc  out  1  load PC (jump).
- wr  out  1  memory write enable.
- data_e  out  1  accumulator drives the data bus.
- illegal  out  1  current instruction is illegal; held while HALTED from a trap.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- state_o  out  4  current state encoding, for debug.

## Operation
Opcodes, 3 LSBs:
- HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- An opcode with any nonzero bit above [2:0] is illegal and is treated as HLT, with illegal=1.

States (4-bit encoding) and outputs. Outputs not listed are 0.
- INST_ADDR=0: sel.
- INST_FETCH=1: sel, rd. Wait-capable.
- INST_LOAD=2: sel, rd, ld_ir.
- IDLE=3: sel.
- OP_ADDR=4: inc_pc.
- OP_FETCH=5: rd if ALUOP. Wait-capable only when ALUOP.
- ALU_OP=6:
  - rd and ld_ac if ALUOP;
  - ld_pc if JMP;
  - inc_pc if SKZ and zero=1.
- STORE=7: wr and data_e if STO. Wait-capable only when STO.
- HALTED=8: halt=1; illegal held if entered by trap.

Transitions:
- A wait-capable state with an active strobe advances only when mem_ready=1. It holds with outputs unchanged otherwise.
- OP_ADDR with HLT or illegal goes to HALTED. inc_pc has already pulsed there, so PC points past the HLT.
- HALTED goes to INST_ADDR when resume=1, and clears the illegal latch.
- Without FAST_PATH, the sequence is strictly 0→1→…→7→0.
- With FAST_PATH:
  - OP_ADDR→ALU_OP for SKZ and JMP.
  - ALU_OP→INST_ADDR for everything except STO.
- instr_done pulses in the last non-HALTED cycle before INST_ADDR, and in OP_ADDR when entering HALTED.
- All outputs are combinational from the state register, opcode and zero. No combinational path from mem_ready or resume to outputs.

## Timing
- Reset: rst low forces INST_ADDR asynchronously from any state, including mid-wait and HALTED. Outputs are then sel=1 and everything else 0. The illegal latch clears.
- With mem_ready tied to 1:
  - every instruction takes 8 cycles without FAST_PATH;
  - with FAST_PATH, ALUOP takes 7, STO 8, SKZ/JMP 6;
  - HLT reaches HALTED 5 cycles after INST_ADDR.
- Each cycle mem_ready is low in a wait-capable state adds exactly one cycle. Outputs are held through the wait.
- resume sampled high in HALTED gives INST_ADDR next cycle. resume is ignored in all other states.
- Simultaneous resume and rst low: reset wins.

## Structure
- Shared package/defines holds the opcode constants, state encodings (4-bit) and the ALUOP predicate, so the datapath decoder uses the same values.
- Single module, no sub-module. The next-state and output logic are two processes over one state register plus the illegal latch.

## Test plan
- Reset and sequencing: reset, mem_ready=1, FAST_PATH=0, opcode=ADD → state_o 0..7 repeating; ld_ac only in state 6; instr_done every 8th cycle.
- Wait states: LDA with mem_ready low for 3 cycles in INST_FETCH and 2 in OP_FETCH → instruction takes 13 cycles; rd held high throughout each wait.
- Branches: SKZ with zero=1 → inc_pc pulses in states 4 and 6. SKZ with zero=0 → one pulse only. JMP → ld_pc=1 only in state 6.
- Halt/illegal: HLT → HALTED at cycle 5 with halt=1; resume high 4 cycles later → INST_ADDR next. OPCODE_W=4 with opcode=4'b1010 → HALTED with illegal=1, which clears on resume.
- FAST_PATH=1: SKZ, JMP, ADD, STO back-to-back → 6, 6, 7, 8 cycles; wr and data_e only in STO's STORE.
- Reset mid-operation: rst low during an STO STORE wait → next sampled state is 0; wr=0 immediately (async).
